// File: rtl/idc_sched.sv
// ---------------------------------------------------------------------------
// idc_sched -- round-robin scheduler that serialises 10-element ID-check
// requests from NREQ requesters into a single ID checker and returns the
// checker's verdict (or a timeout error) tagged with the requester index.
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   req_valid      [NREQ-1:0] per-requester request
//   req_id         [NREQ*60-1:0] requester i owns bits [60i+59:60i], element
//                  k at [60i+6k+5:60i+6k] (element 0 letter code, 9 check digit)
//   req_ready      [NREQ-1:0] one-cycle accept strobe to the granted requester
//   idc_in_valid   element strobe to the checker
//   idc_in_id      [5:0] element value to the checker
//   idc_out_valid  checker result strobe
//   idc_out_legal  checker result value
//   rsp_valid      one-cycle response strobe
//   rsp_tag        [1:0] requester the response belongs to
//   rsp_legal      latched checker verdict
//   rsp_err        1 when the checker timed out
//   busy           high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module idc_sched #(
   parameter int NREQ = 4,
   parameter int TMO  = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*60-1:0]   req_id,
   output logic [NREQ-1:0]      req_ready,
   output logic                 idc_in_valid,
   output logic [5:0]           idc_in_id,
   input  logic                 idc_out_valid,
   input  logic                 idc_out_legal,
   output logic                 rsp_valid,
   output logic [1:0]           rsp_tag,
   output logic                 rsp_legal,
   output logic                 rsp_err,
   output logic                 busy
);

   localparam int WCW = (TMO < 1) ? 1 : $clog2(TMO + 1);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] SEND = 3'd1;
   localparam logic [2:0] WAIT = 3'd2;
   localparam logic [2:0] RESP = 3'd3;
   localparam logic [2:0] COOL = 3'd4;

   logic [2:0]     state;
   logic [1:0]     last_grant;
   logic [1:0]     tag;
   logic [59:0]    id_sh;
   logic [3:0]     send_cnt;
   logic [WCW-1:0] wait_cnt;

   logic [1:0]     grant;
   logic [59:0]    grant_id;

   // Round-robin pick: search from last+1 upward, wrapping. The loop runs
   // backwards so the nearest requester after last is the one that sticks.
   function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] v,
                                          input logic [1:0]      last);
      logic [1:0] idx;
      logic [1:0] pick;
      pick = last;
      for (int i = NREQ; i >= 1; i--) begin
         idx = last + 2'(i);
         if (v[idx]) pick = idx;
      end
      return pick;
   endfunction

   always_comb begin
      grant    = rr_pick(req_valid, last_grant);
      grant_id = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (2'(i) == grant) grant_id = req_id[i*60 +: 60];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         last_grant   <= 2'd3;
         tag          <= 2'd0;
         id_sh        <= '0;
         send_cnt     <= '0;
         wait_cnt     <= '0;
         req_ready    <= '0;
         idc_in_valid <= 1'b0;
         idc_in_id    <= '0;
         rsp_valid    <= 1'b0;
         rsp_tag      <= 2'd0;
         rsp_legal    <= 1'b0;
         rsp_err      <= 1'b0;
         busy         <= 1'b0;
      end else begin
         req_ready <= '0;
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  req_ready  <= NREQ'(1) << grant;
                  last_grant <= grant;
                  tag        <= grant;
                  id_sh      <= grant_id;
                  send_cnt   <= '0;
                  busy       <= 1'b1;
                  state      <= SEND;
               end
            end
            // Elements leave the low end of the shift register one per cycle;
            // the accept cycle itself carries no element.
            SEND: begin
               if (send_cnt == 4'd10) begin
                  idc_in_valid <= 1'b0;
                  idc_in_id    <= '0;
                  wait_cnt     <= '0;
                  state        <= WAIT;
               end else begin
                  idc_in_valid <= 1'b1;
                  idc_in_id    <= id_sh[5:0];
                  id_sh        <= {6'd0, id_sh[59:6]};
                  send_cnt     <= send_cnt + 4'd1;
               end
            end
            // A result arriving on the timeout cycle takes priority.
            WAIT: begin
               if (idc_out_valid) begin
                  rsp_valid <= 1'b1;
                  rsp_tag   <= tag;
                  rsp_legal <= idc_out_legal;
                  rsp_err   <= 1'b0;
                  state     <= RESP;
               end else if (wait_cnt == WCW'(TMO)) begin
                  rsp_valid <= 1'b1;
                  rsp_tag   <= tag;
                  rsp_legal <= 1'b0;
                  rsp_err   <= 1'b1;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               state <= COOL;
            end
            // One idle cycle lets the checker clear its element index.
            COOL: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_idc_sched.sv
// ---------------------------------------------------------------------------
// tb_idc_sched -- directed bench for idc_sched: single request, round-robin
// order, timeout, result-on-timeout boundary, reset during streaming and
// back-to-back requests.
// ---------------------------------------------------------------------------
module tb_idc_sched;

   localparam int NREQ = 4;
   localparam int TMO  = 15;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NREQ-1:0]    req_valid = '0;
   logic [NREQ*60-1:0] req_id = '0;
   logic [NREQ-1:0]    req_ready;
   logic               idc_in_valid;
   logic [5:0]         idc_in_id;
   logic               idc_out_valid = 1'b0;
   logic               idc_out_legal = 1'b0;
   logic               rsp_valid;
   logic [1:0]         rsp_tag;
   logic               rsp_legal;
   logic               rsp_err;
   logic               busy;

   int vectors = 0;
   int miscompares = 0;
   int cycle = 0;
   int grant_cyc = 0;
   int rsp_cyc = 0;

   idc_sched #(.NREQ(NREQ), .TMO(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_id(req_id), .req_ready(req_ready),
      .idc_in_valid(idc_in_valid), .idc_in_id(idc_in_id),
      .idc_out_valid(idc_out_valid), .idc_out_legal(idc_out_legal),
      .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_legal(rsp_legal),
      .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle = cycle + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors = vectors + 1;
      if (got !== exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Requester 0 carries A123456789 = (10,1,2,...,9); others get distinct codes.
   function automatic logic [5:0] elem(input int i, input int k);
      if (i == 0) return (k == 0) ? 6'd10 : 6'(k);
      return 6'((i * 17 + k * 5 + 3) & 63);
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_in_valid", idc_in_valid, 0);
      chk("rst_in_id", idc_in_id, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_tag", rsp_tag, 0);
      chk("rst_rsp_legal", rsp_legal, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_busy", busy, 0);
      step();
      step();
      rst_n = 1'b1;
   endtask

   // One full transaction. d = cycles from last element to checker result
   // (0 = checker never answers).
   task automatic txn(input logic [3:0] rv, input int g, input int d, input logic lv,
                      input logic exp_err, input logic exp_legal);
      int cyc;
      int exp_lat;
      req_valid = rv;
      step();
      chk("grant", req_ready, 64'(4'b0001 << g));
      chk("busy_accept", busy, 1);
      grant_cyc = cycle;
      req_valid[g] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (k == 0) chk("ready_pulse", req_ready, 0);
         chk("in_valid", idc_in_valid, 1);
         chk("in_id", idc_in_id, elem(g, k));
      end
      cyc = 0;
      while (cyc < 60) begin
         step();
         cyc = cyc + 1;
         idc_out_valid = 1'b0;
         idc_out_legal = 1'b0;
         if (cyc == 1) begin
            chk("wait_in_valid", idc_in_valid, 0);
            chk("wait_in_id", idc_in_id, 0);
         end
         if (rsp_valid) break;
         if (cyc == d) begin
            idc_out_valid = 1'b1;
            idc_out_legal = lv;
         end
      end
      exp_lat = (d > 0 && d <= TMO + 1) ? d + 1 : TMO + 2;
      chk("rsp_latency", cyc, exp_lat);
      chk("rsp_tag", rsp_tag, g);
      chk("rsp_legal", rsp_legal, exp_legal);
      chk("rsp_err", rsp_err, exp_err);
      rsp_cyc = cycle;
      step();
      chk("rsp_pulse", rsp_valid, 0);
      chk("busy_cool", busy, 1);
      step();
      chk("busy_idle", busy, 0);
      chk("tag_hold", rsp_tag, g);
      chk("err_hold", rsp_err, exp_err);
   endtask

   initial begin
      int pulses;
      for (int i = 0; i < NREQ; i++)
         for (int k = 0; k < 10; k++)
            req_id[i*60 + k*6 +: 6] = elem(i, k);

      #2;
      do_reset();

      // Single request, checker answers legal two cycles after last element.
      txn(4'b0001, 0, 2, 1'b1, 1'b0, 1'b1);

      // Round-robin from a fresh reset: 0,1,2,3 then 0 again.
      do_reset();
      txn(4'b1111, 0, 1, 1'b0, 1'b0, 1'b0);
      txn(4'b1111, 1, 3, 1'b1, 1'b0, 1'b1);
      txn(4'b1111, 2, 2, 1'b0, 1'b0, 1'b0);
      txn(4'b1111, 3, 5, 1'b1, 1'b0, 1'b1);
      txn(4'b1111, 0, 1, 1'b1, 1'b0, 1'b1);
      req_valid = '0;

      // Timeout: search from 1 finds requester 2.
      txn(4'b0100, 2, 0, 1'b0, 1'b1, 1'b0);

      // Result on the timeout cycle wins; search from 3 wraps to 0.
      txn(4'b0101, 0, TMO + 1, 1'b1, 1'b0, 1'b1);
      req_valid = '0;

      // Back-to-back: requester 2 stays pending while requester 1 is served.
      txn(4'b0110, 1, 2, 1'b1, 1'b0, 1'b1);
      begin
         int r1;
         r1 = rsp_cyc;
         txn(req_valid, 2, 1, 1'b0, 1'b0, 1'b0);
         chk("b2b_gap_ge2", ((grant_cyc - r1) >= 2) ? 1 : 0, 1);
      end
      req_valid = '0;

      // Reset in the middle of SEND after element 4.
      req_valid = 4'b0001;
      step();
      chk("mid_grant", req_ready, 4'b0001);
      req_valid = '0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("mid_in_id", idc_in_id, elem(0, k));
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_valid", idc_in_valid, 0);
      chk("mid_rst_busy", busy, 0);
      step();
      rst_n = 1'b1;
      pulses = 0;
      for (int c = 0; c < 25; c++) begin
         step();
         if (rsp_valid) pulses = pulses + 1;
      end
      chk("mid_no_rsp", pulses, 0);
      txn(4'b1010, 1, 1, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/idc_sched.md
IDC_SCHED -- requirements
Module: idc_sched

Interface
REQ-001 The block SHALL use parameter NREQ, default 4, as the number of requesters (fixed at 4 in this revision).
REQ-002 The block SHALL use parameter TMO, default 15, as the maximum number of wait cycles for a checker result.
REQ-003 The block SHALL have the following ports, listed as name, direction, width, meaning:
- clk  in  1  clock; all registers update on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  4  per-requester ID-check request.
- req_id  in  240  requester i owns bits [60i+59:60i]; element k occupies bits [60i+6k+5:60i+6k]; element 0 is the letter code and element 9 is the check digit.
- req_ready  out  1 per requester (4 total)  one-cycle accept strobe to the granted requester.
- idc_in_valid  out  1  drives the checker's in_valid.
- idc_in_id  out  6  drives the checker's in_id.
- idc_out_valid  in  1  checker result strobe.
- idc_out_legal  in  1  checker result value.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_tag  out  2  index of the requester the response belongs to.
- rsp_legal  out  1  latched checker verdict.
- rsp_err  out  1  set to 1 on timeout.
- busy  out  1  high in every state except IDLE.

Function
REQ-004 The FSM SHALL have the states IDLE, SEND, WAIT, RESP and COOL, and every output SHALL be driven from a register.
REQ-005 In IDLE with any req_valid bit high at cycle T, the block SHALL select requester g by round-robin, pulse req_ready[g]=1 during T only, latch req_id of g and g into the tag register at the end of T, and enter SEND.
REQ-006 Round-robin SHALL search from index (last_grant+1) mod 4 upward; after reset the search SHALL start at index 0.
REQ-007 In SEND, for cycles T+1 to T+10, the block SHALL drive idc_in_valid=1 and idc_in_id=element k, with k=0..9 in order and no gaps; after the 10th element it SHALL enter WAIT.
REQ-008 In WAIT, idc_in_valid SHALL be 0 and idc_in_id SHALL be 0, and a wait counter SHALL start at 0 and increment once per cycle.
REQ-009 If idc_out_valid=1 is sampled in WAIT, the block SHALL latch idc_out_legal into rsp_legal, set rsp_err=0, and enter RESP.
REQ-010 If the wait counter reaches TMO without idc_out_valid, the block SHALL set rsp_legal=0 and rsp_err=1, and enter RESP.
REQ-011 If idc_out_valid arrives in the same cycle the wait counter reaches TMO, the result SHALL win (rsp_err=0).
REQ-012 idc_out_valid SHALL be ignored in IDLE, SEND, RESP and COOL.
REQ-013 In RESP, the block SHALL assert rsp_valid=1 for exactly one cycle, with rsp_tag=g and rsp_legal/rsp_err as latched; it SHALL then enter COOL.
REQ-014 COOL SHALL last 1 cycle, then the FSM SHALL return to IDLE, so that the checker has time to clear its internal index before the next stream.
REQ-015 req_valid and req_id changes outside the accept cycle SHALL be ignored, and only one request SHALL be in flight at a time.
REQ-016 A requester SHALL hold req_valid and req_id stable until it sees req_ready; a requester that drops req_valid before grant SHALL simply not be selected.
REQ-017 rsp_tag, rsp_legal and rsp_err SHALL hold their values after RESP until the next RESP overwrites them.
REQ-018 Minimum request-to-response time SHALL be: accept at T, last element at T+10, result at T+10+d (d>=1), rsp_valid at T+11+d.

Reset
REQ-019 On assertion of rst_n=0, the block SHALL immediately force state=IDLE, req_ready=0, idc_in_valid=0, idc_in_id=0, rsp_valid=0, rsp_tag=0, rsp_legal=0, rsp_err=0, busy=0, last_grant=3 and all counters to 0.
REQ-020 A reset in the middle of SEND or WAIT SHALL abort the transaction with no response issued; the first post-reset grant SHALL follow REQ-005.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Single request: req_valid=4'b0001, ID A123456789 coded (10,1,2,3,4,5,6,7,8,9); checker returns legal=1 two cycles after the last element -> 10 consecutive idc_in_id values 10,1..9; rsp_valid with tag=0, legal=1, err=0 at T+13.
- Round-robin: req_valid=4'b1111 held for 4 transactions -> grant order 0,1,2,3, then 0 again on re-request; each req_ready pulse lasts exactly one cycle.
- Timeout: the checker never asserts out_valid -> rsp_valid with err=1, legal=0, exactly TMO+1 cycles after WAIT entry.
- Boundary: result and timeout in the same cycle -> err=0, and legal equals the checker value.
- Reset mid-SEND after element 4 -> idc_in_valid drops immediately and no rsp_valid is issued; a new request afterwards streams from element 0.
- Back-to-back: a second request pending during a response -> the next req_ready appears no earlier than 2 cycles after rsp_valid (RESP, COOL, then IDLE grant).
